// File: rtl/squash_input_conditioner.sv
// Button front end for the solo_squash core. It synchronises and debounces the four raw
// active-low buttons, then derives the pause latch, the new-game strobe and the up/down keys.
module squash_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter bit PAUSE_TOGGLE    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pause_n,
    input  logic btn_new_game_n,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic pause_n,
    output logic new_game_n,
    output logic up_key_n,
    output logic down_key_n
);

    localparam int N_CH    = 4;
    localparam int CH_PAUSE = 0;
    localparam int CH_NEW   = 1;
    localparam int CH_UP    = 2;
    localparam int CH_DOWN  = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0]  raw_s;
    logic [N_CH-1:0]  sync1_r;
    logic [N_CH-1:0]  sync2_r;
    logic [N_CH-1:0]  st_r;
    logic [CNT_W-1:0] cnt_r [N_CH];
    logic [1:0]       st_d_r;
    logic             press_pause_s;
    logic             press_new_s;
    logic             paused_r;

    assign raw_s = {btn_down_n, btn_up_n, btn_new_game_n, btn_pause_n};

    // Two-flop synchroniser for the asynchronous buttons; released level is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Stability-counter debouncer: a new level is accepted only after it has been
    // seen for DEBOUNCE_CYCLES consecutive cycles; any return to st restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_r <= 4'b1111;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_r[ch] <= CNT_ZERO;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (sync2_r[ch] == st_r[ch]) begin
                    cnt_r[ch] <= CNT_ZERO;
                end else if (cnt_r[ch] == CNT_LAST) begin
                    st_r[ch]  <= sync2_r[ch];
                    cnt_r[ch] <= CNT_ZERO;
                end else begin
                    cnt_r[ch] <= cnt_r[ch] + CNT_ONE;
                end
            end
        end
    end

    // Delayed copy of the pause and new-game levels for press (falling) edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_d_r <= 2'b11;
        end else begin
            st_d_r <= {st_r[CH_NEW], st_r[CH_PAUSE]};
        end
    end

    assign press_pause_s = st_d_r[0] & ~st_r[CH_PAUSE];
    assign press_new_s   = st_d_r[1] & ~st_r[CH_NEW];

    // Pause latch: a new-game press always clears it, even when pause is pressed together.
    always_ff @(posedge clk) begin
        if (reset) begin
            paused_r <= 1'b0;
        end else if (press_new_s) begin
            paused_r <= 1'b0;
        end else if (PAUSE_TOGGLE && press_pause_s) begin
            paused_r <= ~paused_r;
        end else begin
            paused_r <= paused_r;
        end
    end

    // Output decode, purely from registered state; up and down lock each other out.
    always_comb begin
        pause_n    = 1'b1;
        new_game_n = 1'b1;
        up_key_n   = 1'b1;
        down_key_n = 1'b1;
        if (PAUSE_TOGGLE) begin
            pause_n = ~paused_r;
        end else begin
            pause_n = st_r[CH_PAUSE];
        end
        new_game_n = ~press_new_s;
        up_key_n   = st_r[CH_UP] | ~st_r[CH_DOWN];
        down_key_n = st_r[CH_DOWN] | ~st_r[CH_UP];
    end

endmodule
